raw_bayer_demosaic: RTL and testbench

RAW_BAYER_DEMOSAIC -- requirements
Module: raw_bayer_demosaic

---
 rtl/raw_bayer_demosaic.sv | 178 +++++++++++++++++
 tb/tb_raw_bayer_demosaic.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/raw_bayer_demosaic.sv
// Two-line Bayer demosaic: 2x2 window, phase-selected RGB, 2-cycle pipeline.
// Optional per-frame green statistics (oGSUM) are built only when FRAME_STATS_EN is defined.
module raw_bayer_demosaic (
  input  logic        VGA_CLK,
  input  logic        RESET_N,
  input  logic        READ_Request,
  input  logic        VGA_VS,
  input  logic [12:0] V_Cont,
  input  logic [9:0]  taps0x,
  input  logic [9:0]  taps1x,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oDVAL
`ifdef FRAME_STATS_EN
  ,
  output logic [31:0] oGSUM
`endif
);

  // Average of two 10-bit samples (11-bit add, >>1), then truncated to bits [9:2].
  function automatic logic [7:0] avg_green(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[10:3];
  endfunction

  logic        rd_q;
  logic        line_act_q, line_act_d;
  logic [11:0] col_q, col_d;
  logic [9:0]  p00_q, p01_q, p10_q, p11_q;
  logic [9:0]  p00_d, p01_d, p10_d, p11_d;
  logic [1:0]  ph_q, ph_d;
  logic        v1_q, v1_d;
  logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        dval_q, dval_d;

  logic        first_col;
  logic        accept;
  logic        rd_fall;
  logic [9:0]  r_sel, b_sel;
  logic [7:0]  g_sel;

  // Only the row parity bit of the line number matters here.
  logic unused_vcont;
  assign unused_vcont = ^V_Cont[12:1];

  // Stage 1: line-start detection, column counter and window shift.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    p00_d      = p00_q;
    p01_d      = p01_q;
    p10_d      = p10_q;
    p11_d      = p11_q;
    ph_d       = ph_q;
    col_d      = col_q;

    first_col  = READ_Request & ~rd_q;
    rd_fall    = ~READ_Request & rd_q;
    accept     = READ_Request & VGA_VS & (first_col | line_act_q);
    v1_d       = accept;
    line_act_d = READ_Request & VGA_VS & (line_act_q | first_col);

    if (accept) begin
      ph_d = {V_Cont[0], col_q[0]};
      if (first_col) begin
        p00_d = taps1x;
        p01_d = taps1x;
        p10_d = taps0x;
        p11_d = taps0x;
      end else begin
        p00_d = p01_q;
        p10_d = p11_q;
        p01_d = taps1x;
        p11_d = taps0x;
      end
    end

    if (!VGA_VS || rd_fall) begin
      col_d = '0;
    end else if (accept) begin
      col_d = col_q + 12'd1;
    end
  end

  // Stage 2: phase-dependent colour selection, blanked while invalid.
  always_comb begin
    r_sel = '0;
    b_sel = '0;
    g_sel = '0;
    unique case (ph_q)
      2'b11: begin r_sel = p00_q; g_sel = avg_green(p01_q, p10_q); b_sel = p11_q; end
      2'b10: begin r_sel = p01_q; g_sel = avg_green(p00_q, p11_q); b_sel = p10_q; end
      2'b01: begin r_sel = p10_q; g_sel = avg_green(p00_q, p11_q); b_sel = p01_q; end
      2'b00: begin r_sel = p11_q; g_sel = avg_green(p01_q, p10_q); b_sel = p00_q; end
      default: ;
    endcase

    dval_d  = v1_q & VGA_VS;
    red_d   = dval_d ? r_sel[9:2] : 8'd0;
    green_d = dval_d ? g_sel      : 8'd0;
    blue_d  = dval_d ? b_sel[9:2] : 8'd0;
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the window is a handful of flops, so it is reset like any other state rather than left undefined.
      p00_q      <= '0;
      p01_q      <= '0;
      p10_q      <= '0;
      p11_q      <= '0;
      ph_q       <= '0;
      col_q      <= '0;
      v1_q       <= 1'b0;
      line_act_q <= 1'b0;
      // Reset looks like "request already high" so a line in progress is never picked up mid-way.
      rd_q       <= 1'b1;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      dval_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      p00_q      <= p00_d;
      p01_q      <= p01_d;
      p10_q      <= p10_d;
      p11_q      <= p11_d;
      ph_q       <= ph_d;
      col_q      <= col_d;
      v1_q       <= v1_d;
      line_act_q <= line_act_d;
      rd_q       <= READ_Request;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      dval_q     <= dval_d;
    end
  end

  assign oRed   = red_q;
  assign oGreen = green_q;
  assign oBlue  = blue_q;
  assign oDVAL  = dval_q;

`ifdef FRAME_STATS_EN
  logic        vs_q;
  logic [31:0] acc_q, acc_d, gsum_q, gsum_d;
  logic [32:0] acc_sum;
  logic [31:0] acc_sat;

  // The pixel on the output in the VS-falling cycle is folded into the snapshot.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {25'd0, (dval_q ? green_q : 8'd0)};
    acc_sat = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
    acc_d   = acc_sat;
    gsum_d  = gsum_q;
    if (vs_q && !VGA_VS) begin
      gsum_d = acc_sat;
      acc_d  = '0;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_q   <= 1'b0;
      acc_q  <= '0;
      gsum_q <= '0;
    end else begin
      vs_q   <= VGA_VS;
      acc_q  <= acc_d;
      gsum_q <= gsum_d;
    end
  end

  assign oGSUM = gsum_q;
`endif

endmodule

// File: tb/tb_raw_bayer_demosaic.sv
// Directed + scoreboard bench for raw_bayer_demosaic; every cycle's output is checked against the queue.
// Define FRAME_STATS_EN for both files to exercise the oGSUM statistics.
module tb_raw_bayer_demosaic;

  logic        VGA_CLK;
  logic        RESET_N;
  logic        READ_Request;
  logic        VGA_VS;
  logic [12:0] V_Cont;
  logic [9:0]  taps0x;
  logic [9:0]  taps1x;
  logic [7:0]  oRed, oGreen, oBlue;
  logic        oDVAL;
`ifdef FRAME_STATS_EN
  logic [31:0] oGSUM;
`endif

  raw_bayer_demosaic dut (
    .VGA_CLK      (VGA_CLK),
    .RESET_N      (RESET_N),
    .READ_Request (READ_Request),
    .VGA_VS       (VGA_VS),
    .V_Cont       (V_Cont),
    .taps0x       (taps0x),
    .taps1x       (taps1x),
    .oRed         (oRed),
    .oGreen       (oGreen),
    .oBlue        (oBlue),
    .oDVAL        (oDVAL)
`ifdef FRAME_STATS_EN
    ,
    .oGSUM        (oGSUM)
`endif
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct packed {
    int          due;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference state for the pixel window.
  logic [9:0]  m00, m01, m10, m11;
  logic [11:0] m_col;
  logic        m_rd, m_act;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m00 = '0; m01 = '0; m10 = '0; m11 = '0;
    m_col = '0;
    m_rd  = 1'b1;
    m_act = 1'b0;
    sb.delete();
  endtask

  function automatic logic [23:0] ref_rgb(input int p00, input int p01, input int p10,
                                          input int p11, input logic [1:0] ph);
    int r, g, b;
    case (ph)
      2'b11:   begin r = p00; g = (p01 + p10) / 2; b = p11; end
      2'b10:   begin r = p01; g = (p00 + p11) / 2; b = p10; end
      2'b01:   begin r = p10; g = (p00 + p11) / 2; b = p01; end
      default: begin r = p11; g = (p01 + p10) / 2; b = p00; end
    endcase
    return {8'(r / 4), 8'(g / 4), 8'(b / 4)};
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge VGA_CLK);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("pix_dval", {31'd0, oDVAL}, 32'd1);
      check("pix_rgb", {8'd0, oRed, oGreen, oBlue}, {8'd0, e.rgb});
    end else begin
      check("idle_dval", {31'd0, oDVAL}, 32'd0);
      check("idle_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
    end
  endtask

  // One input cycle; an accepted pixel pushes either a fixed expectation (use_k) or the model's.
  task automatic drive(input logic rr, input logic vs, input logic [12:0] vc,
                       input logic [9:0] t1, input logic [9:0] t0,
                       input logic use_k = 1'b0, input logic [23:0] k = 24'd0);
    logic first, acc;
    logic [1:0] ph;
    exp_t e;
    READ_Request = rr;
    VGA_VS       = vs;
    V_Cont       = vc;
    taps1x       = t1;
    taps0x       = t0;
    first = rr && !m_rd;
    acc   = rr && vs && (first || m_act);
    if (acc) begin
      ph = {vc[0], m_col[0]};
      if (first) begin
        m00 = t1; m01 = t1; m10 = t0; m11 = t0;
      end else begin
        m00 = m01; m10 = m11; m01 = t1; m11 = t0;
      end
      e.due = cyc + 2;
      e.rgb = use_k ? k : ref_rgb(int'(m00), int'(m01), int'(m10), int'(m11), ph);
      sb.push_back(e);
    end
    m_act = rr && vs && (m_act || first);
    if (!vs || (!rr && m_rd)) m_col = '0;
    else if (acc)             m_col = m_col + 12'd1;
    m_rd = rr;
    if (!vs) sb.delete();
    tick();
  endtask

  task automatic idle(input int n, input logic vs = 1'b1);
    for (int i = 0; i < n; i++) drive(1'b0, vs, 13'd0, 10'd0, 10'd0);
  endtask

  task automatic rand_line(input logic [12:0] vc, input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, vc, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; READ_Request = 1'b0; VGA_VS = 1'b0;
    V_Cont = '0; taps0x = '0; taps1x = '0;
    model_reset();
    #2;
    check("reset_dval", {31'd0, oDVAL}, 32'd0);
    check("reset_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
`ifdef FRAME_STATS_EN
    check("reset_gsum", oGSUM, 32'd0);
`endif
    #10 RESET_N = 1'b1;
    idle(2);

    // Flat field: R=G=B=FF from the third cycle.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 13'd1, 10'h3FC, 10'h3FC, 1'b1, 24'hFFFFFF);
    idle(3);

    // Replicated first column then the 2x2 window 100/200/300/400 in phase 11.
    drive(1'b1, 1'b1, 13'd1, 10'd100, 10'd300, 1'b1, {8'd25, 8'd50, 8'd75});
    drive(1'b1, 1'b1, 13'd1, 10'd200, 10'd400, 1'b1, {8'd25, 8'd62, 8'd100});
    idle(3);

    // Line-start replication in phase 00.
    drive(1'b1, 1'b1, 13'd2, 10'd40, 10'd80, 1'b1, {8'd20, 8'd15, 8'd10});
    idle(3);

    // Random line, then mid-line drop drains two pixels.
    rand_line(13'd3, 12);
    idle(3);

    // Long line wrapping the column counter.
    rand_line(13'd0, 4100);
    idle(3);

    // VS falls with pixels in flight while the request is still high.
    rand_line(13'd4, 5);
    drive(1'b1, 1'b0, 13'd4, 10'd7, 10'd9);
    idle(2, 1'b0);
    idle(1);

    // Asynchronous reset mid-line; request held high afterwards must not restart the line.
    rand_line(13'd5, 4);
    RESET_N = 1'b0;
    #1;
    check("midreset_dval", {31'd0, oDVAL}, 32'd0);
    check("midreset_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
`ifdef FRAME_STATS_EN
    check("midreset_gsum", oGSUM, 32'd0);
`endif
    #1 RESET_N = 1'b1;
    model_reset();
    rand_line(13'd5, 4);
    idle(1);
    rand_line(13'd5, 3);
    idle(3);

    // Frame statistics: 100 pixels of G=0x10, then a short second frame.
    idle(1, 1'b0);
    idle(1);
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 13'd6, 10'd64, 10'd64, 1'b1, {8'd16, 8'd16, 8'd16});
    idle(3);
    idle(1, 1'b0);
`ifdef FRAME_STATS_EN
    check("gsum_frame1", oGSUM, 32'd1600);
`endif
    idle(1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 13'd7, 10'd64, 10'd64, 1'b1, {8'd16, 8'd16, 8'd16});
    idle(3);
    idle(1, 1'b0);
`ifdef FRAME_STATS_EN
    check("gsum_frame2", oGSUM, 32'd64);
`endif
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
